blake2_host_seq: RTL and testbench

Host-side sequencer for the BLAKE2s core's 8-bit byte interface. It takes a job (key length, digest length, message length) plus a byte stream of key and message data, and drives the core's data, valid and command pins. It zero-pads the key block and the final message block, then collects the streamed digest and checks the core for timeout. It sits between a host FIFO/UART bridge and the core's `ui_in`/`uio_in` pins in the FPGA emulation top, replacing manual PMOD driving.

---
 rtl/blake2_host_pkg.sv | 29 ++
 rtl/blake2_host_timeout.sv | 39 +++
 rtl/blake2_host_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_blake2_host_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blake2_host_pkg.sv
// Shared types and constants for the BLAKE2s host-side byte sequencer.
package blake2_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_KEY,
    ST_DATA,
    ST_WAIT_HASH,
    ST_READ_HASH,
    ST_ERR
  } state_e;

  localparam logic [1:0] CMD_CFG   = 2'b00;
  localparam logic [1:0] CMD_FIRST = 2'b01;
  localparam logic [1:0] CMD_DATA  = 2'b10;
  localparam logic [1:0] CMD_LAST  = 2'b11;

  localparam int BLOCK_BYTES = 64;
  localparam int MAX_NN      = 32;
  localparam int MAX_KK      = 32;

  localparam logic [5:0] LAST_BYTE = 6'(BLOCK_BYTES - 1);

  function automatic logic cfg_legal(input logic [5:0] kk, input logic [5:0] nn);
    return (nn != 6'd0) && (int'(nn) <= MAX_NN) && (int'(kk) <= MAX_KK);
  endfunction

endpackage

// File: rtl/blake2_host_timeout.sv
// Loadable saturating cycle counter; expired_o flags the last allowed
// counting cycle so the owner can leave on the TIMEOUT_CYCLES-th edge.
module blake2_host_timeout #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int            CW    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default assigned first so every path drives cnt_d; no latch is inferred.
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignment for state so all flops update together at the edge.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/blake2_host_seq.sv
// Host-side sequencer: streams config, key and message blocks into the BLAKE2s
// byte interface with zero padding, then collects the digest and watches for timeout.
module blake2_host_seq #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [5:0]  kk_i,
  input  logic [5:0]  nn_i,
  input  logic [15:0] ll_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  input  logic [7:0]  msg_data_i,
  input  logic        msg_valid_i,
  output logic        msg_ready_o,
  output logic [7:0]  hash_data_o,
  output logic        hash_valid_o,
  output logic [7:0]  core_data_o,
  output logic        core_valid_o,
  output logic [1:0]  core_cmd_o,
  input  logic        core_ready_i,
  input  logic        core_hash_valid_i,
  input  logic [7:0]  core_hash_i
);

  import blake2_host_pkg::*;

  state_e      state_q, state_d;
  logic [5:0]  kk_q, kk_d;
  logic [5:0]  nn_q, nn_d;
  logic [15:0] ll_q, ll_d;
  logic [5:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] rem_q, rem_d;
  logic [5:0]  dig_cnt_q, dig_cnt_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        hash_valid_q, hash_valid_d;
  logic [7:0]  hash_data_q, hash_data_d;

  logic streaming;
  logic final_byte;
  logic xfer;
  logic capture;
  logic to_expired;

  blake2_host_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (state_q != ST_WAIT_HASH),
    .en_i     (state_q == ST_WAIT_HASH),
    .expired_o(to_expired)
  );

  // Core-side byte mux: bypass the host stream or inject pad/config bytes.
  always_comb begin
    core_valid_o = 1'b0;
    core_data_o  = 8'h00;
    core_cmd_o   = CMD_CFG;
    msg_ready_o  = 1'b0;
    streaming    = 1'b0;
    final_byte   = 1'b0;

    unique case (state_q)
      ST_CFG: begin
        core_valid_o = 1'b1;
        unique case (byte_cnt_q[1:0])
          2'd0:    core_data_o = {2'b00, kk_q};
          2'd1:    core_data_o = {2'b00, nn_q};
          2'd2:    core_data_o = ll_q[7:0];
          default: core_data_o = ll_q[15:8];
        endcase
      end
      ST_KEY: begin
        streaming  = byte_cnt_q < kk_q;
        final_byte = (byte_cnt_q == LAST_BYTE) && (ll_q == 16'd0);
      end
      ST_DATA: begin
        // The final block is the one whose byte 63 leaves no message behind it.
        streaming  = rem_q != 16'd0;
        final_byte = (byte_cnt_q == LAST_BYTE) && (rem_q <= 16'd1);
      end
      default: ;
    endcase

    if (state_q inside {ST_KEY, ST_DATA}) begin
      if (byte_cnt_q == 6'd0) begin
        core_cmd_o = CMD_FIRST;
      end else if (final_byte) begin
        core_cmd_o = CMD_LAST;
      end else begin
        core_cmd_o = CMD_DATA;
      end

      if (streaming) begin
        core_valid_o = msg_valid_i;
        core_data_o  = msg_data_i;
        msg_ready_o  = core_ready_i;
      end else begin
        core_valid_o = 1'b1;
      end
    end
  end

  assign xfer = core_valid_o & core_ready_i;

  always_comb begin
    state_d      = state_q;
    kk_d         = kk_q;
    nn_d         = nn_q;
    ll_d         = ll_q;
    byte_cnt_d   = byte_cnt_q;
    rem_d        = rem_q;
    dig_cnt_d    = dig_cnt_q;
    err_d        = err_q;
    done_d       = 1'b0;
    hash_valid_d = 1'b0;
    hash_data_d  = hash_data_q;
    capture      = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start_i) begin
          if (cfg_legal(kk_i, nn_i)) begin
            kk_d       = kk_i;
            nn_d       = nn_i;
            ll_d       = ll_i;
            rem_d      = ll_i;
            byte_cnt_d = 6'd0;
            dig_cnt_d  = 6'd0;
            err_d      = 1'b0;
            state_d    = ST_CFG;
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end
        end
      end
      ST_CFG: begin
        if (xfer) begin
          if (byte_cnt_q == 6'd3) begin
            byte_cnt_d = 6'd0;
            state_d    = (kk_q != 6'd0) ? ST_KEY : ST_DATA;
          end else begin
            byte_cnt_d = byte_cnt_q + 6'd1;
          end
        end
      end
      ST_KEY: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 6'd1;
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = (ll_q == 16'd0) ? ST_WAIT_HASH : ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 6'd1;
          if (streaming) begin
            rem_d = rem_q - 16'd1;
          end
          if (final_byte) begin
            state_d = ST_WAIT_HASH;
          end
        end
      end
      ST_WAIT_HASH: begin
        if (core_hash_valid_i) begin
          capture = 1'b1;
          state_d = ST_READ_HASH;
        end else if (to_expired) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end
      end
      ST_READ_HASH: begin
        // Stay busy through the done_o cycle so a coincident start_i is ignored.
        if (done_q) begin
          state_d = ST_IDLE;
        end else if (dig_cnt_q == nn_q) begin
          done_d = 1'b1;
        end else if (core_hash_valid_i) begin
          capture = 1'b1;
        end else begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      hash_valid_d = 1'b1;
      hash_data_d  = core_hash_i;
      dig_cnt_d    = dig_cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      kk_q         <= 6'd0;
      nn_q         <= 6'd0;
      ll_q         <= 16'd0;
      byte_cnt_q   <= 6'd0;
      rem_q        <= 16'd0;
      dig_cnt_q    <= 6'd0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      hash_valid_q <= 1'b0;
      hash_data_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      kk_q         <= kk_d;
      nn_q         <= nn_d;
      ll_q         <= ll_d;
      byte_cnt_q   <= byte_cnt_d;
      rem_q        <= rem_d;
      dig_cnt_q    <= dig_cnt_d;
      err_q        <= err_d;
      done_q       <= done_d;
      hash_valid_q <= hash_valid_d;
      hash_data_q  <= hash_data_d;
    end
  end

  assign busy_o       = !(state_q inside {ST_IDLE, ST_ERR});
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign hash_valid_o = hash_valid_q;
  assign hash_data_o  = hash_data_q;

endmodule

// File: tb/tb_blake2_host_seq.sv
// Scoreboard bench for blake2_host_seq: expected core bytes and digest bytes are
// queued from a block-layout model and compared as the DUT emits them.
module tb_blake2_host_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [5:0]  kk_i;
  logic [5:0]  nn_i;
  logic [15:0] ll_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [7:0]  msg_data_i;
  logic        msg_valid_i;
  logic        msg_ready_o;
  logic [7:0]  hash_data_o;
  logic        hash_valid_o;
  logic [7:0]  core_data_o;
  logic        core_valid_o;
  logic [1:0]  core_cmd_o;
  logic        core_ready_i;
  logic        core_hash_valid_i;
  logic [7:0]  core_hash_i;

  blake2_host_seq #(.TIMEOUT_CYCLES(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_i          (start_i),
    .kk_i             (kk_i),
    .nn_i             (nn_i),
    .ll_i             (ll_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .err_o            (err_o),
    .msg_data_i       (msg_data_i),
    .msg_valid_i      (msg_valid_i),
    .msg_ready_o      (msg_ready_o),
    .hash_data_o      (hash_data_o),
    .hash_valid_o     (hash_valid_o),
    .core_data_o      (core_data_o),
    .core_valid_o     (core_valid_o),
    .core_cmd_o       (core_cmd_o),
    .core_ready_i     (core_ready_i),
    .core_hash_valid_i(core_hash_valid_i),
    .core_hash_i      (core_hash_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  bit thr      = 1'b0;

  logic [9:0] exp_core[$];
  logic [7:0] exp_hash[$];
  logic [7:0] stream[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [31:0] outs();
    return 32'({busy_o, done_o, err_o, msg_ready_o, hash_valid_o, core_valid_o,
                core_cmd_o, core_data_o, hash_data_o});
  endfunction

  // Host stream and core-ready driver, updated just after each rising edge.
  initial begin
    core_ready_i = 1'b1;
    msg_valid_i  = 1'b0;
    msg_data_i   = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      core_ready_i = thr ? ($urandom_range(0, 3) != 0) : 1'b1;
      msg_valid_i  = (stream.size() > 0) && (thr ? ($urandom_range(0, 3) != 0) : 1'b1);
      msg_data_i   = (stream.size() > 0) ? stream[0] : 8'h00;
    end
  end

  // Monitor on the falling edge: core transfers, digest bytes and done pulses.
  initial begin : monitor
    logic [9:0] e;
    logic [7:0] h;
    bit prev_hv;
    prev_hv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (core_valid_o && core_ready_i) begin
          if (exp_core.size() == 0) begin
            check("core_extra", 32'(exp_core.size()), 32'd1);
          end else begin
            e = exp_core.pop_front();
            check("core_byte", 32'({core_cmd_o, core_data_o}), 32'(e));
          end
        end
        if (msg_valid_i && msg_ready_o && stream.size() > 0) void'(stream.pop_front());
        if (hash_valid_o) begin
          if (exp_hash.size() == 0) begin
            check("hash_extra", 32'(exp_hash.size()), 32'd1);
          end else begin
            h = exp_hash.pop_front();
            check("hash_byte", 32'(hash_data_o), 32'(h));
          end
        end
        if (done_o) begin
          done_cnt++;
          check("done_after_last", 32'({prev_hv, exp_hash.size() == 0}), 32'b11);
          check("done_busy", 32'(busy_o), 32'd1);
        end
        prev_hv = hash_valid_o;
      end else begin
        prev_hv = 1'b0;
      end
    end
  end

  task automatic pulse_start(input int kk, input int nn, input int ll);
    @(posedge clk);
    #1;
    kk_i    = 6'(kk);
    nn_i    = 6'(nn);
    ll_i    = 16'(ll);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  // Block-layout model: config, optional key block, zero-padded message blocks.
  task automatic start_job(input int kk, input int nn, input int ll);
    logic [7:0] key[$];
    logic [7:0] msg[$];
    logic [7:0] d;
    logic [1:0] c;
    int nblk;
    for (int i = 0; i < kk; i++) key.push_back(8'($urandom));
    for (int i = 0; i < ll; i++) msg.push_back(8'($urandom));
    exp_core.push_back({2'b00, 8'(kk)});
    exp_core.push_back({2'b00, 8'(nn)});
    exp_core.push_back({2'b00, 8'(ll & 255)});
    exp_core.push_back({2'b00, 8'(ll >> 8)});
    if (kk > 0) begin
      for (int i = 0; i < 64; i++) begin
        d = (i < kk) ? key[i] : 8'h00;
        c = (i == 0) ? 2'b01 : ((i == 63 && ll == 0) ? 2'b11 : 2'b10);
        exp_core.push_back({c, d});
      end
    end
    nblk = (ll == 0) ? ((kk == 0) ? 1 : 0) : (ll + 63) / 64;
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < 64; i++) begin
        d = (b * 64 + i < ll) ? msg[b * 64 + i] : 8'h00;
        c = (i == 0) ? 2'b01 : ((i == 63 && b == nblk - 1) ? 2'b11 : 2'b10);
        exp_core.push_back({c, d});
      end
    end
    foreach (key[i]) stream.push_back(key[i]);
    foreach (msg[i]) stream.push_back(msg[i]);
    pulse_start(kk, nn, ll);
    check("start_busy_err", 32'({busy_o, err_o}), 32'b10);
  endtask

  // Returns just after the edge that takes the last core byte.
  task automatic wait_core_drain();
    int cyc = 0;
    while (exp_core.size() != 0 && cyc < 8000) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check("core_drained", 32'(exp_core.size()), 32'd0);
    check("stream_used", 32'(stream.size()), 32'd0);
  endtask

  task automatic send_hash(input int n);
    for (int j = 0; j < n; j++) begin
      core_hash_valid_i = 1'b1;
      core_hash_i       = 8'($urandom);
      exp_hash.push_back(core_hash_i);
      @(posedge clk);
      #1;
    end
    core_hash_valid_i = 1'b0;
    core_hash_i       = 8'h00;
  endtask

  task automatic wait_done();
    int start_cnt = done_cnt;
    int cyc = 0;
    while (done_cnt == start_cnt && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    check("done_seen", 32'(done_cnt - start_cnt), 32'd1);
    @(posedge clk);
    #1;
    check("idle_after_done", 32'({busy_o, err_o, done_o}), 32'd0);
    check("hash_drained", 32'(exp_hash.size()), 32'd0);
  endtask

  task automatic run_job(input int kk, input int nn, input int ll);
    start_job(kk, nn, ll);
    wait_core_drain();
    send_hash(nn);
    wait_done();
  endtask

  initial begin
    int first_err;
    int cyc;
    int dc;
    rst_n             = 1'b0;
    start_i           = 1'b0;
    kk_i              = 6'd0;
    nn_i              = 6'd0;
    ll_i              = 16'd0;
    core_hash_valid_i = 1'b0;
    core_hash_i       = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("in_reset_outs", outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after_reset_outs", outs(), 32'd0);

    run_job(0, 32, 0);
    run_job(0, 16, 65);
    run_job(4, 32, 3);

    thr = 1'b1;
    run_job(5, 20, 130);
    thr = 1'b0;

    // Digest never arrives: ERR exactly 16 edges after WAIT_HASH entry.
    start_job(0, 8, 0);
    wait_core_drain();
    first_err = 0;
    cyc = 0;
    while (first_err == 0 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (err_o) first_err = cyc;
    end
    check("timeout_cycles", 32'(first_err), 32'd16);
    check("timeout_busy", 32'(busy_o), 32'd0);

    // Legal start from ERR clears the flag; full-key, exact-block message.
    run_job(32, 1, 64);

    pulse_start(0, 0, 5);
    check("nn0_err_busy", 32'({err_o, busy_o}), 32'b10);
    pulse_start(33, 4, 5);
    check("kk33_err_busy", 32'({err_o, busy_o}), 32'b10);

    // Digest stream stops early.
    dc = done_cnt;
    start_job(0, 4, 10);
    wait_core_drain();
    send_hash(2);
    repeat (3) @(posedge clk);
    #1;
    check("short_hash_err", 32'({err_o, busy_o}), 32'b10);
    check("short_hash_nodone", 32'(done_cnt - dc), 32'd0);
    check("short_hash_drained", 32'(exp_hash.size()), 32'd0);

    // Reset in the middle of DATA.
    dc = done_cnt;
    start_job(0, 4, 100);
    cyc = 0;
    while (exp_core.size() > 100 && cyc < 500) begin
      @(posedge clk);
      cyc++;
    end
    check("reached_data", 32'(exp_core.size() <= 100), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", outs(), 32'd0);
    exp_core.delete();
    stream.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_nodone", 32'(done_cnt - dc), 32'd0);
    run_job(2, 8, 70);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
